mem_arbiter: RTL

//  Shares one single-ported backing memory between the IF-stage fetch port and the MEM-stage data port.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Function : Shared FSM state encodings and port ids for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Function : Fetch, data and backing-memory signals of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          if_stall;
    logic          mem_stall;
    logic          timeout_err;

    // The arbiter itself
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, if_stall, mem_stall, timeout_err
    );

    // Pipeline requesters plus backing memory
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, if_stall, mem_stall, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arb_watchdog
// Function : Counts busy cycles since the last grant; flags the TIMEOUT-th one.
// Revision : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_limit = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_one   = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_one;
        end
    end

    // Count holds busy cycles already elapsed, so this busy cycle is number TIMEOUT
    assign o_expired = i_enable && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Function : Shares one single-ported memory between fetch and data ports.
// Options  : ARB_ROUND_ROBIN_EN - alternate grants on collision (else data wins)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_timeout_err;
    logic          w_pend_i;
    logic          w_pend_d;
    logic          w_grant;
    logic          w_grant_port;
    logic          w_done;
    logic          w_abort;
    logic          w_expired;
    logic          w_busy;

    // A port being acked this cycle is not pending, so it cannot be regranted
    assign w_pend_i = bus.i_req & ~r_i_ack;
    assign w_pend_d = bus.d_req & ~r_d_ack;
    assign w_busy   = (r_state != ST_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= PORT_I;
        end else if (w_grant) begin
            r_last_grant <= w_grant_port;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_port = PORT_D;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_i && w_pend_d) begin
                    w_grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    w_grant_port = (r_last_grant == PORT_D) ? PORT_I : PORT_D;
`else
                    w_grant_port = PORT_D;
`endif
                end else if (w_pend_d) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_D;
                end else if (w_pend_i) begin
                    w_grant      = 1'b1;
                    w_grant_port = PORT_I;
                end
                if (w_grant) begin
                    w_state_nxt = (w_grant_port == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // An ack arriving on the expiry cycle still completes normally
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_i_ack       <= 1'b0;
            r_d_ack       <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            if (w_grant) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= (w_grant_port == PORT_D) ? bus.d_we : 1'b0;
                r_mem_addr  <= (w_grant_port == PORT_D) ? bus.d_addr : bus.i_addr;
                r_mem_wdata <= (w_grant_port == PORT_D) ? bus.d_wdata : '0;
            end
            if (w_done || w_abort) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_BUSY_I) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_done ? bus.mem_rdata : '0;
                end else begin
                    r_d_ack <= 1'b1;
                    if (w_abort) begin
                        r_d_rdata <= '0;
                    end else if (!r_mem_we) begin
                        r_d_rdata <= bus.mem_rdata;
                    end
                end
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_grant),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.i_ack       = r_i_ack;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_ack       = r_d_ack;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.timeout_err = r_timeout_err;
    // Stalls are forced low while reset is held so every output reads 0
    assign bus.if_stall    = reset & bus.i_req & ~r_i_ack;
    assign bus.mem_stall   = reset & bus.d_req & ~r_d_ack;

endmodule
`default_nettype wire
